can_frame_tx: RTL and testbench

Single-clock CAN 2.0A data-frame transmitter. It sends one frame with an 11-bit identifier and one data byte: standard base-format frame, DLC=1. Internally it contains a rising-edge one-shot on the request input, a CRC-15 generator and a bit stuffer. It sits between the host logic and the CAN transceiver: tx drives the transceiver TXD, rx is the transceiver RXD readback.

---
 rtl/can_frame_tx.sv | 210 +++++++++++++++++++++
 tb/tb_can_frame_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/can_frame_tx.sv
// CAN 2.0A base-format data-frame transmitter (11-bit ID, DLC=1) with CRC-15,
// bit stuffing, arbitration-loss detection and ACK-slot checking.
module can_frame_tx #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send_data,
  input  logic [10:0] address,
  input  logic [7:0]  data,
  input  logic        rx,
  input  logic        clear_to_tx,
  output logic        tx,
  output logic        can_bitstuff,
  output logic        txing,
  output logic        tx_done,
  output logic        arb_lost,
  output logic        ack_err
);
  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [14:0]   CRC_POLY = 15'h4599;

  typedef enum logic [3:0] {
    IDLE, SOF, ID, CTRL, DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF, IFS
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    run_q, run_d;
  logic [14:0]   crc_q, crc_d;
  logic [10:0]   addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          pend_q, pend_d, send_q, cts_q;
  logic          tx_q, tx_d, stuff_q, stuff_d, txing_q, txing_d;
  logic          done_q, done_d, arb_q, arb_d, ackerr_q, ackerr_d;
  logic          req_pulse, bit_end, arb_zone, crc_zone, stuff_zone, nxt_bit;

  function automatic logic [3:0] last_idx(state_e s);
    case (s)
      ID:      last_idx = 4'd10;
      CTRL:    last_idx = 4'd6;
      DATA:    last_idx = 4'd7;
      CRC:     last_idx = 4'd14;
      EOF:     last_idx = 4'd6;
      IFS:     last_idx = 4'd2;
      default: last_idx = 4'd0;
    endcase
  endfunction

  function automatic state_e succ(state_e s);
    case (s)
      SOF:     succ = ID;
      ID:      succ = CTRL;
      CTRL:    succ = DATA;
      DATA:    succ = CRC;
      CRC:     succ = CRC_DEL;
      CRC_DEL: succ = ACK;
      ACK:     succ = ACK_DEL;
      ACK_DEL: succ = EOF;
      EOF:     succ = IFS;
      default: succ = IDLE;
    endcase
  endfunction

  // Unstuffed bit at (state, index); CTRL is RTR,IDE,r0 then DLC=0001.
  function automatic logic frame_bit(state_e s, logic [3:0] i, logic [10:0] a,
                                     logic [7:0] d, logic [14:0] c);
    logic [10:0] sa;
    logic [7:0]  sd;
    logic [14:0] sc;
    sa = a << i;
    sd = d << i;
    sc = c << i;
    case (s)
      SOF:     frame_bit = 1'b0;
      ID:      frame_bit = sa[10];
      CTRL:    frame_bit = (i == 4'd6);
      DATA:    frame_bit = sd[7];
      CRC:     frame_bit = sc[14];
      default: frame_bit = 1'b1;
    endcase
  endfunction

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    crc_d    = crc_q;
    addr_d   = addr_q;
    data_d   = data_q;
    pend_d   = pend_q;
    tx_d     = tx_q;
    stuff_d  = stuff_q;
    txing_d  = txing_q;
    done_d   = 1'b0;
    arb_d    = 1'b0;
    ackerr_d = 1'b0;
    nxt_bit  = 1'b1;

    req_pulse  = send_data & ~send_q;
    bit_end    = (cnt_q == CNT_LAST);
    arb_zone   = (state_q == ID) || (state_q == CTRL && idx_q == 4'd0);
    crc_zone   = (state_q inside {SOF, ID, CTRL, DATA});
    stuff_zone = crc_zone || (state_q == CRC);

    if (state_q == IDLE) begin
      if (req_pulse) begin
        addr_d = address;
        data_d = data;
        pend_d = 1'b1;
      end
      if (pend_q && cts_q) begin
        state_d = SOF;
        idx_d   = 4'd0;
        cnt_d   = '0;
        crc_d   = 15'h0;
        run_d   = 3'd1;
        tx_d    = 1'b0;
        stuff_d = 1'b0;
        txing_d = 1'b1;
      end
    end else begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      if (bit_end) begin
        if (arb_zone && tx_q && !rx) begin
          // Lost arbitration: back off but keep the request pending for retry.
          state_d = IDLE;
          tx_d    = 1'b1;
          stuff_d = 1'b0;
          txing_d = 1'b0;
          arb_d   = 1'b1;
        end else if (state_q == IFS && idx_q == last_idx(IFS)) begin
          state_d = IDLE;
          txing_d = 1'b0;
          pend_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          ackerr_d = (state_q == ACK) && rx;
          if (!stuff_q && crc_zone)
            crc_d = {crc_q[13:0], 1'b0} ^ ((tx_q ^ crc_q[14]) ? CRC_POLY : 15'h0);
          if (!stuff_q && stuff_zone && run_q == 3'd5) begin
            stuff_d = 1'b1;
            tx_d    = ~tx_q;
            run_d   = 3'd1;
          end else begin
            if (idx_q == last_idx(state_q)) begin
              state_d = succ(state_q);
              idx_d   = 4'd0;
            end else begin
              idx_d = idx_q + 4'd1;
            end
            nxt_bit = frame_bit(state_d, idx_d, addr_q, data_q, crc_d);
            stuff_d = 1'b0;
            tx_d    = nxt_bit;
            run_d   = (nxt_bit == tx_q && run_q != 3'd7) ? run_q + 3'd1 : 3'd1;
          end
        end
      end
    end
  end

  // clear_to_tx is registered before use, so a frame starts two clks after it rises.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= 4'd0;
      cnt_q    <= '0;
      run_q    <= 3'd0;
      crc_q    <= 15'h0;
      addr_q   <= 11'h0;
      data_q   <= 8'h0;
      pend_q   <= 1'b0;
      send_q   <= 1'b0;
      cts_q    <= 1'b0;
      tx_q     <= 1'b1;
      stuff_q  <= 1'b0;
      txing_q  <= 1'b0;
      done_q   <= 1'b0;
      arb_q    <= 1'b0;
      ackerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      crc_q    <= crc_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      pend_q   <= pend_d;
      send_q   <= send_data;
      cts_q    <= clear_to_tx;
      tx_q     <= tx_d;
      stuff_q  <= stuff_d;
      txing_q  <= txing_d;
      done_q   <= done_d;
      arb_q    <= arb_d;
      ackerr_q <= ackerr_d;
    end
  end

  assign tx           = tx_q;
  assign can_bitstuff = stuff_q;
  assign txing        = txing_q;
  assign tx_done      = done_q;
  assign arb_lost     = arb_q;
  assign ack_err      = ackerr_q;
endmodule

// File: tb/tb_can_frame_tx.sv
// Bench for can_frame_tx: a queue-based frame model (CRC + stuffing from the
// frame rules) gives the expected tx/can_bitstuff for every clk of a frame.
module tb_can_frame_tx;
  localparam int CPB = 10;

  logic        clk = 1'b0, rst = 1'b0, send_data = 1'b0, rx = 1'b1, clear_to_tx = 1'b1;
  logic [10:0] address = 11'h0;
  logic [7:0]  data = 8'h0;
  logic        tx, can_bitstuff, txing, tx_done, arb_lost, ack_err;

  int total = 0, pass = 0;

  bit          sq_v[$], sq_s[$], sq_arb[$];
  int          ack_pos, data_pos, m_nstuff;
  logic [14:0] m_crc;

  always #5 clk = ~clk;

  can_frame_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .send_data(send_data), .address(address), .data(data),
    .rx(rx), .clear_to_tx(clear_to_tx), .tx(tx), .can_bitstuff(can_bitstuff),
    .txing(txing), .tx_done(tx_done), .arb_lost(arb_lost), .ack_err(ack_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Build the expected on-wire bit sequence for one frame.
  task automatic build(input logic [10:0] a, input logic [7:0] d);
    bit          u[$];
    logic [14:0] c;
    bit          nx;
    int          run;
    c = 15'h0;
    u.push_back(1'b0);
    for (int i = 10; i >= 0; i--) u.push_back(a[i]);
    repeat (3) u.push_back(1'b0);
    for (int i = 3; i >= 0; i--) u.push_back(i == 0);
    for (int i = 7; i >= 0; i--) u.push_back(d[i]);
    foreach (u[i]) begin
      nx = u[i] ^ c[14];
      c  = {c[13:0], 1'b0};
      if (nx) c = c ^ 15'h4599;
    end
    m_crc = c;
    for (int i = 14; i >= 0; i--) u.push_back(c[i]);
    sq_v.delete(); sq_s.delete(); sq_arb.delete();
    run = 0; m_nstuff = 0; data_pos = 0;
    for (int i = 0; i < 42; i++) begin
      if (sq_v.size() > 0 && u[i] == sq_v[$]) run++;
      else run = 1;
      if (i == 19) data_pos = sq_v.size();
      sq_v.push_back(u[i]); sq_s.push_back(1'b0); sq_arb.push_back(i >= 1 && i <= 12);
      if (run == 5) begin
        sq_v.push_back(!u[i]); sq_s.push_back(1'b1); sq_arb.push_back(i >= 1 && i <= 12);
        run = 1; m_nstuff++;
      end
    end
    for (int i = 0; i < 13; i++) begin
      if (i == 1) ack_pos = sq_v.size();
      sq_v.push_back(1'b1); sq_s.push_back(1'b0); sq_arb.push_back(1'b0);
    end
  endtask

  task automatic pulse();
    send_data = 1'b1;
    @(posedge clk); #1;
    send_data = 1'b0;
  endtask

  task automatic idle_chk(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rx = 1'b1;
      chk("idle_tx", tx, 1);
      chk("idle_txing", txing, 0);
      chk("idle_pulses", {tx_done, arb_lost, ack_err, can_bitstuff}, 0);
    end
  endtask

  // Called one clk before SOF is due; checks every clk of the frame.
  task automatic run_frame(input bit ack_rx, input int arb_at, input int rst_at);
    int n;
    n = sq_v.size();
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < CPB; c++) begin
        @(posedge clk); #1;
        chk("tx", tx, sq_v[k]);
        chk("bitstuff", can_bitstuff, sq_s[k]);
        chk("txing", txing, 1);
        chk("tx_done", tx_done, 0);
        chk("arb_lost", arb_lost, 0);
        chk("ack_err", ack_err, (k == ack_pos + 1 && c == 0) ? ack_rx : 1'b0);
        rx = (k == arb_at) ? 1'b0 : (k == ack_pos) ? ack_rx : sq_v[k];
        if (k == arb_at) clear_to_tx = 1'b0;
        if (k == 3) send_data = (c == 1);
        if (k == n - 1 && c == CPB - 1) send_data = 1'b1;
        if (k == rst_at && c == 3) begin
          rst = 1'b0;
          return;
        end
        if (k == arb_at && c == CPB - 1) begin
          @(posedge clk); #1;
          chk("arb_pulse", arb_lost, 1);
          chk("arb_tx", tx, 1);
          chk("arb_txing", txing, 0);
          rx = 1'b1;
          return;
        end
      end
    end
    @(posedge clk); #1;
    send_data = 1'b0;
    rx = 1'b1;
    chk("done_pulse", tx_done, 1);
    chk("done_txing", txing, 0);
    chk("done_tx", tx, 1);
    chk("done_ackerr", ack_err, 0);
    @(posedge clk); #1;
    chk("done_clear", tx_done, 0);
  endtask

  task automatic arb_retry();
    idle_chk(20);
    clear_to_tx = 1'b1;
    @(posedge clk); #1;
    chk("retry_wait", tx, 1);
    run_frame(1'b0, -1, -1);
    idle_chk(5);
  endtask

  initial begin
    int  cand[$];
    int  arb;
    bit  ackr;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_txing", txing, 0);
    chk("rst_pulses", {tx_done, arb_lost, ack_err, can_bitstuff}, 0);
    rst = 1'b1;
    idle_chk(200);

    // Zero frame, with hand-derived pins on the model.
    address = 11'h0; data = 8'h0;
    build(address, data);
    chk("model_crc_zero", m_crc, 15'h4426);
    chk("model_nstuff_zero", m_nstuff, 4);
    chk("model_len_zero", sq_v.size(), 59);
    chk("model_first6", {sq_v[0], sq_v[1], sq_v[2], sq_v[3], sq_v[4], sq_v[5]}, 6'b000001);
    chk("model_stuff6", {sq_s[0], sq_s[1], sq_s[2], sq_s[3], sq_s[4], sq_s[5]}, 6'b000001);
    pulse();
    chk("latency_tx", tx, 1);
    run_frame(1'b0, -1, -1);
    idle_chk(10);

    // Gating on clear_to_tx.
    clear_to_tx = 1'b0;
    address = 11'h2A5; data = 8'h3C;
    build(address, data);
    pulse();
    idle_chk(100);
    clear_to_tx = 1'b1;
    @(posedge clk); #1;
    chk("gate_wait", tx, 1);
    run_frame(1'b0, -1, -1);
    idle_chk(5);

    // Arbitration loss on ID bit 10, then retry.
    address = 11'h7FF; data = 8'hFF;
    build(address, data);
    pulse();
    run_frame(1'b0, 1, -1);
    arb_retry();

    // No ACK.
    address = 11'd123; data = 8'd255;
    build(address, data);
    pulse();
    run_frame(1'b1, -1, -1);
    idle_chk(5);

    // Mid-frame reset during DATA, then a clean frame.
    address = 11'h155; data = 8'hA5;
    build(address, data);
    pulse();
    run_frame(1'b0, -1, data_pos + 2);
    @(posedge clk); #1;
    chk("mrst_tx", tx, 1);
    chk("mrst_txing", txing, 0);
    chk("mrst_stuff", can_bitstuff, 0);
    rst = 1'b1;
    idle_chk(30);
    address = 11'h0F0; data = 8'h0F;
    build(address, data);
    pulse();
    run_frame(1'b0, -1, -1);
    idle_chk(5);

    // Randomized frames, some with arbitration loss at a random recessive bit.
    for (int f = 0; f < 9; f++) begin
      address = 11'($urandom);
      data    = 8'($urandom);
      ackr    = 1'($urandom);
      build(address, data);
      pulse();
      if (f % 3 == 2) begin
        cand.delete();
        foreach (sq_v[i]) if (sq_arb[i] && sq_v[i]) cand.push_back(i);
        if (cand.size() > 0) begin
          arb = cand[$urandom_range(cand.size() - 1)];
          run_frame(1'b0, arb, -1);
          arb_retry();
          continue;
        end
      end
      run_frame(ackr, -1, -1);
      idle_chk(5);
    end

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
